// File: rtl/typer_char_feeder_pkg.sv
// Shared constants for the text typer: screen geometry, control codes and feeder FSM states.
package typer_char_feeder_pkg;

  localparam int TEXT_COLS   = 32;
  localparam int TEXT_ROWS   = 7;
  localparam int CHAR_WIDTH  = 20;
  localparam int CHAR_HEIGHT = 30;
  localparam int FIFO_DEPTH  = 16;

  localparam logic [7:0] CODE_BS    = 8'h08;
  localparam logic [7:0] CODE_CR    = 8'h0D;
  localparam logic [7:0] CODE_SPACE = 8'h20;

  localparam logic [7:0] LAST_COL = 8'(TEXT_COLS - 1);
  localparam logic [7:0] LAST_ROW = 8'(TEXT_ROWS - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DECODE  = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_ADVANCE = 3'd4
  } feeder_state_t;

  // Next row down, wrapping to the top instead of scrolling.
  function automatic logic [7:0] next_row(input logic [7:0] row);
    return (row == LAST_ROW) ? 8'd0 : row + 8'd1;
  endfunction

endpackage

// File: rtl/typer_char_feeder_char_fifo.sv
// First-word-fall-through character queue; a push is accepted when full only if a pop happens the same cycle.
module char_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/typer_char_feeder.sv
// Queues keyboard character codes, tracks the text cursor and issues one glyph-write request at a time.
module typer_char_feeder
  import typer_char_feeder_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] char_in,
  input  logic       char_valid,
  input  logic       writer_done,
  output logic [7:0] row_num,
  output logic [7:0] col_num,
  output logic [7:0] char_code,
  output logic       write_start,
  output logic       fifo_full,
  output logic       overflow
);

  feeder_state_t state, next_state;

  logic [7:0] cur_code, next_cur_code;
  logic       erase, next_erase;
  logic [7:0] next_row_num, next_col_num, next_char_code;
  logic       fifo_pop;
  logic       fifo_empty;
  logic [7:0] fifo_dout;

  char_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock(clock),
    .reset(reset),
    .push (char_valid),
    .pop  (fifo_pop),
    .din  (char_in),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // row_num/col_num double as the cursor; they only move in DECODE and ADVANCE, so stay stable during a request.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      cur_code    <= '0;
      erase       <= 1'b0;
      row_num     <= '0;
      col_num     <= '0;
      char_code   <= '0;
      write_start <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state       <= next_state;
      cur_code    <= next_cur_code;
      erase       <= next_erase;
      row_num     <= next_row_num;
      col_num     <= next_col_num;
      char_code   <= next_char_code;
      write_start <= (next_state == ST_ISSUE);
      if (char_valid && fifo_full && !fifo_pop) overflow <= 1'b1;
    end
  end

  always_comb begin
    next_state     = state;
    next_cur_code  = cur_code;
    next_erase     = erase;
    next_row_num   = row_num;
    next_col_num   = col_num;
    next_char_code = char_code;
    fifo_pop       = 1'b0;

    case (state)
      ST_IDLE: begin
        if (!fifo_empty && writer_done) begin
          fifo_pop      = 1'b1;
          next_cur_code = fifo_dout;
          next_state    = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (cur_code == CODE_CR) begin
          next_col_num = 8'd0;
          next_row_num = next_row(row_num);
          next_state   = ST_IDLE;
        end else if (cur_code == CODE_BS) begin
          if (col_num != 8'd0) begin
            next_col_num   = col_num - 8'd1;
            next_erase     = 1'b1;
            next_char_code = CODE_SPACE;
            next_state     = ST_ISSUE;
          end else if (row_num != 8'd0) begin
            next_row_num   = row_num - 8'd1;
            next_col_num   = LAST_COL;
            next_erase     = 1'b1;
            next_char_code = CODE_SPACE;
            next_state     = ST_ISSUE;
          end else begin
            next_state = ST_IDLE;
          end
        end else begin
          next_erase     = 1'b0;
          next_char_code = cur_code;
          next_state     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!writer_done) next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (writer_done) next_state = ST_ADVANCE;
      end
      ST_ADVANCE: begin
        // An erase leaves the cursor on the blanked cell so the next char overwrites it.
        if (!erase) begin
          if (col_num == LAST_COL) begin
            next_col_num = 8'd0;
            next_row_num = next_row(row_num);
          end else begin
            next_col_num = col_num + 8'd1;
          end
        end
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_typer_char_feeder.sv
// Directed bench for typer_char_feeder with a behavioural glyph writer that stays busy for 600 cycles per glyph.
module tb_typer_char_feeder;

  logic       clock;
  logic       reset;
  logic [7:0] char_in;
  logic       char_valid;
  logic       writer_done;
  logic [7:0] row_num;
  logic [7:0] col_num;
  logic [7:0] char_code;
  logic       write_start;
  logic       fifo_full;
  logic       overflow;

  int check_count = 0;
  int error_count = 0;

  logic       writer_stall;
  int         busy_left;
  int         write_count;
  logic [7:0] cap_row  [256];
  logic [7:0] cap_col  [256];
  logic [7:0] cap_code [256];

  localparam int BUSY_CYCLES = 600;

  typer_char_feeder dut (
    .clock      (clock),
    .reset      (reset),
    .char_in    (char_in),
    .char_valid (char_valid),
    .writer_done(writer_done),
    .row_num    (row_num),
    .col_num    (col_num),
    .char_code  (char_code),
    .write_start(write_start),
    .fifo_full  (fifo_full),
    .overflow   (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Writer model: latches a request on negedge, then stays busy for BUSY_CYCLES.
  initial begin
    writer_done  = 1'b1;
    writer_stall = 1'b0;
    busy_left    = 0;
    write_count  = 0;
    forever begin
      @(negedge clock);
      if (busy_left > 0) begin
        busy_left = busy_left - 1;
      end else if (write_start && writer_done) begin
        if (write_count < 256) begin
          cap_row[write_count]  = row_num;
          cap_col[write_count]  = col_num;
          cap_code[write_count] = char_code;
        end
        write_count = write_count + 1;
        busy_left   = BUSY_CYCLES;
      end
      writer_done = !writer_stall && (busy_left == 0);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyReset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] code);
    @(negedge clock);
    char_in    = code;
    char_valid = 1'b1;
    @(negedge clock);
    char_valid = 1'b0;
  endtask

  // Waits (bounded) until `target` writes were captured and the request has fully retired.
  task automatic waitWrites(input int target);
    int budget;
    budget = (BUSY_CYCLES + 50) * ((target > write_count) ? (target - write_count) : 1) + 50;
    while (!(write_count >= target && writer_done) && budget > 0) begin
      @(negedge clock);
      budget--;
    end
    if (budget == 0) checkOutput("wait_timeout", write_count, target);
    repeat (4) @(negedge clock);
  endtask

  task automatic sendPrint(input logic [7:0] code);
    int target;
    target = write_count + 1;
    applyStimulus(code);
    waitWrites(target);
  endtask

  task automatic sendControl(input logic [7:0] code);
    applyStimulus(code);
    repeat (8) @(negedge clock);
  endtask

  initial begin
    int base;
    reset      = 1'b1;
    char_in    = 8'h00;
    char_valid = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // Reset state
    checkOutput("rst_row", row_num, 8'd0);
    checkOutput("rst_col", col_num, 8'd0);
    checkOutput("rst_code", char_code, 8'd0);
    checkOutput("rst_start", write_start, 1'b0);
    checkOutput("rst_full", fifo_full, 1'b0);
    checkOutput("rst_ovf", overflow, 1'b0);

    // 1: single printable
    base = write_count;
    sendPrint(8'h41);
    checkOutput("t1_count", write_count, base + 1);
    checkOutput("t1_row", cap_row[base], 8'd0);
    checkOutput("t1_col", cap_col[base], 8'd0);
    checkOutput("t1_code", cap_code[base], 8'h41);
    checkOutput("t1_cur_row", row_num, 8'd0);
    checkOutput("t1_cur_col", col_num, 8'd1);

    // 2: 33 printables wrap onto row 1
    applyReset();
    base = write_count;
    for (int i = 0; i < 33; i++) sendPrint(8'h21 + 8'(i));
    checkOutput("t2_count", write_count, base + 33);
    checkOutput("t2_w32_row", cap_row[base + 31], 8'd0);
    checkOutput("t2_w32_col", cap_col[base + 31], 8'd31);
    checkOutput("t2_w32_code", cap_code[base + 31], 8'h40);
    checkOutput("t2_w33_row", cap_row[base + 32], 8'd1);
    checkOutput("t2_w33_col", cap_col[base + 32], 8'd0);
    checkOutput("t2_w33_code", cap_code[base + 32], 8'h41);
    checkOutput("t2_cur_row", row_num, 8'd1);
    checkOutput("t2_cur_col", col_num, 8'd1);

    // 3: backspace erases, and is a no-op at the origin
    applyReset();
    base = write_count;
    sendPrint(8'h41);
    sendPrint(8'h42);
    sendPrint(8'h08);
    checkOutput("t3_bs_row", cap_row[base + 2], 8'd0);
    checkOutput("t3_bs_col", cap_col[base + 2], 8'd1);
    checkOutput("t3_bs_code", cap_code[base + 2], 8'h20);
    checkOutput("t3_cur_row", row_num, 8'd0);
    checkOutput("t3_cur_col", col_num, 8'd1);
    applyReset();
    base = write_count;
    sendControl(8'h08);
    checkOutput("t3_bs00_nowrite", write_count, base);
    checkOutput("t3_bs00_row", row_num, 8'd0);
    checkOutput("t3_bs00_col", col_num, 8'd0);

    // 4: CR from (3,5), and full wrap from (6,31)
    applyReset();
    repeat (3) sendControl(8'h0D);
    for (int i = 0; i < 5; i++) sendPrint(8'h61 + 8'(i));
    checkOutput("t4_pre_row", row_num, 8'd3);
    checkOutput("t4_pre_col", col_num, 8'd5);
    base = write_count;
    sendControl(8'h0D);
    checkOutput("t4_cr_nowrite", write_count, base);
    checkOutput("t4_cr_row", row_num, 8'd4);
    checkOutput("t4_cr_col", col_num, 8'd0);
    repeat (2) sendControl(8'h0D);
    for (int i = 0; i < 31; i++) sendPrint(8'h30 + 8'(i % 10));
    checkOutput("t4_edge_row", row_num, 8'd6);
    checkOutput("t4_edge_col", col_num, 8'd31);
    base = write_count;
    sendPrint(8'h50);
    checkOutput("t4_last_row", cap_row[base], 8'd6);
    checkOutput("t4_last_col", cap_col[base], 8'd31);
    checkOutput("t4_wrap_row", row_num, 8'd0);
    checkOutput("t4_wrap_col", col_num, 8'd0);

    // 5: fill the queue while the writer is stalled
    applyReset();
    writer_stall = 1'b1;
    repeat (2) @(negedge clock);
    base = write_count;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      char_in    = 8'h50 + 8'(i);
      char_valid = 1'b1;
    end
    @(negedge clock);
    checkOutput("t5_full16", fifo_full, 1'b1);
    checkOutput("t5_ovf_before", overflow, 1'b0);
    char_in = 8'h7A;
    @(negedge clock);
    char_valid = 1'b0;
    checkOutput("t5_ovf_after", overflow, 1'b1);
    writer_stall = 1'b0;
    waitWrites(base + 16);
    repeat (BUSY_CYCLES + 50) @(negedge clock);
    checkOutput("t5_count", write_count, base + 16);
    for (int i = 0; i < 16; i++) checkOutput($sformatf("t5_code%0d", i), cap_code[base + i], 8'h50 + 8'(i));
    checkOutput("t5_full_drained", fifo_full, 1'b0);
    checkOutput("t5_ovf_sticky", overflow, 1'b1);

    // 6: reset while a request is in WAIT
    applyReset();
    sendPrint(8'h58);
    base = write_count;
    applyStimulus(8'h5A);
    begin
      int budget = 100;
      while (write_count == base && budget > 0) begin
        @(negedge clock);
        budget--;
      end
    end
    checkOutput("t6_started", write_count, base + 1);
    repeat (5) @(negedge clock);
    checkOutput("t6_wait_start", write_start, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("t6_rst_start", write_start, 1'b0);
    checkOutput("t6_rst_row", row_num, 8'd0);
    checkOutput("t6_rst_col", col_num, 8'd0);
    checkOutput("t6_rst_full", fifo_full, 1'b0);
    reset = 1'b0;
    base = write_count;
    applyStimulus(8'h51);
    repeat (10) @(negedge clock);
    checkOutput("t6_held_count", write_count, base);
    checkOutput("t6_held_start", write_start, 1'b0);
    checkOutput("t6_writer_busy", writer_done, 1'b0);
    waitWrites(base + 1);
    checkOutput("t6_after_count", write_count, base + 1);
    checkOutput("t6_after_row", cap_row[base], 8'd0);
    checkOutput("t6_after_col", cap_col[base], 8'd0);
    checkOutput("t6_after_code", cap_code[base], 8'h51);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
